baud_tick_gen: RTL and testbench

Parametrised successor to the fixed-table baud divider. From a configurable system clock it generates single-cycle oversample ticks, a mid-bit sample tick and a bit-boundary tick for five selectable baud rates. Non-integer clock/baud ratios are handled with a fractional error accumulator. It sits between the clock source and the UART TX/RX engines, and a rate change takes effect only at a bit boundary.

---
 rtl/baud_pkg.sv | 35 +++
 rtl/baud_tick_gen_if.sv | 32 +++
 rtl/baud_frac_div.sv | 115 +++++++++++
 rtl/baud_tick_gen.sv | 151 +++++++++++++++
 tb/tb_baud_tick_gen.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/baud_pkg.sv
// ---------------------------------------------------------------------------
// baud_pkg
// Shared constants and helpers for the baud tick generator.
//   NUM_RATES          number of selectable baud rates
//   DEFAULT_OVERSAMPLE ticks per bit unless overridden
//   BAUD_TABLE         baud rate per rate index (9600 .. 115200)
//   ACC_W              width of the fractional error accumulator
//   rate_idx_t         rate index type (3 bits, 0..4 valid)
//   DEFAULT_RATE       rate index after reset
//   baud_div/baud_rem  integer part / remainder of clk_hz / (baud * os)
// ---------------------------------------------------------------------------
package baud_pkg;

    localparam int NUM_RATES = 5;
    localparam int unsigned DEFAULT_OVERSAMPLE = 16;
    localparam int unsigned BAUD_TABLE [NUM_RATES] = '{9600, 19200, 38400, 57600, 115200};
    localparam int ACC_W = 32;

    typedef logic [2:0] rate_idx_t;

    localparam rate_idx_t DEFAULT_RATE = 3'd0;

    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        return clk_hz / (baud * os);
    endfunction

    function automatic int unsigned baud_rem(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        return clk_hz % (baud * os);
    endfunction

endpackage

// File: rtl/baud_tick_gen_if.sv
// ---------------------------------------------------------------------------
// baud_tick_gen_if
// Control and tick bundle between the baud tick generator and its users.
//   en        run enable                         (master -> slave)
//   sel       requested rate select              (master -> slave)
//   tick_os   oversample tick, one cycle wide    (slave -> master)
//   tick_mid  mid-bit sample tick                (slave -> master)
//   tick_bit  bit-boundary tick                  (slave -> master)
//   rate_idx  rate index currently in effect     (slave -> master)
//   sel_err   sel is outside the valid range    (slave -> master)
// ---------------------------------------------------------------------------
interface baud_tick_gen_if;

    logic                en;
    logic [2:0]          sel;
    logic                tick_os;
    logic                tick_mid;
    logic                tick_bit;
    baud_pkg::rate_idx_t rate_idx;
    logic                sel_err;

    modport master (
        output en, sel,
        input  tick_os, tick_mid, tick_bit, rate_idx, sel_err
    );

    modport slave (
        input  en, sel,
        output tick_os, tick_mid, tick_bit, rate_idx, sel_err
    );

endinterface

// File: rtl/baud_frac_div.sv
// ---------------------------------------------------------------------------
// baud_frac_div
// Period counter with optional fractional error accumulator. Each period is
// div_i or div_i+1 clocks long; the long/short decision is made in the first
// cycle of a period (cnt = 0) from the running error and rem_i / mod_i.
// Optional feature: `BAUD_FRAC_EN. Without it every period is div_i clocks
// and the error register does not exist.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   en_i       run enable; low clears counter, error and tick
//   load_i     new divisor in effect for the period starting now; clears err
//   div_i      integer divisor D (>= 2)
//   rem_i      remainder R          (BAUD_FRAC_EN only)
//   mod_i      modulus M = baud*OS  (BAUD_FRAC_EN only)
//   wrap_o     combinational: this is the last cycle of the period
//   tick_os_o  registered one-cycle pulse after each period end
// ---------------------------------------------------------------------------
module baud_frac_div
    import baud_pkg::*;
#(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
`ifdef BAUD_FRAC_EN
    input  logic [ACC_W-1:0] rem_i,
    input  logic [ACC_W-1:0] mod_i,
`endif
    output logic             wrap_o,
    output logic             tick_os_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_os_q, tick_os_d;
    logic             period_long;
    logic             period_last;

`ifdef BAUD_FRAC_EN
    logic             long_q, long_d;
    logic [ACC_W-1:0] err_q, err_d;
    logic [ACC_W-1:0] err_base;
    logic [ACC_W:0]   acc_sum;

    // A rate change starts its first period from a clean error.
    assign err_base = load_i ? '0 : err_q;
    // One extra bit so err + R cannot wrap before the compare with M.
    assign acc_sum  = {1'b0, err_base} + {1'b0, rem_i};

    always_comb begin
        long_d = long_q;
        err_d  = err_q;
        if (!en_i) begin
            long_d = 1'b0;
            err_d  = '0;
        end else if (cnt_q == '0) begin
            if (acc_sum >= {1'b0, mod_i}) begin
                long_d = 1'b1;
                err_d  = ACC_W'(acc_sum - {1'b0, mod_i});
            end else begin
                long_d = 1'b0;
                err_d  = acc_sum[ACC_W-1:0];
            end
        end else if (load_i) begin
            err_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            long_q <= 1'b0;
            err_q  <= '0;
        end else begin
            long_q <= long_d;
            err_q  <= err_d;
        end
    end

    assign period_long = long_q;
`else
    assign period_long = 1'b0;
`endif

    // D >= 2, so the terminal count is never 0 and the long/short flag
    // written in the cnt = 0 cycle is always settled by the time it is used.
    assign period_last = period_long ? (cnt_q == div_i)
                                     : (cnt_q == div_i - 1'b1);
    assign wrap_o      = en_i & period_last;

    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        tick_os_d = 1'b0;
        if (!en_i) begin
            cnt_d = '0;
        end else if (period_last) begin
            cnt_d     = '0;
            tick_os_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            tick_os_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tick_os_q <= tick_os_d;
        end
    end

    assign tick_os_o = tick_os_q;

endmodule

// File: rtl/baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
// Oversample / mid-bit / bit-boundary tick generator for five baud rates.
// Rate changes requested through sel take effect only at a bit boundary
// (the cycle tick_bit is high); with en low they load immediately.
// Optional feature: `BAUD_FRAC_EN enables the fractional error accumulator
// in baud_frac_div so the mean period is exactly CLK_HZ/(baud*OVERSAMPLE).
// Parameters: CLK_HZ, OVERSAMPLE (even, >= 4), DIV_W (period counter width).
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   baud_tick_gen_if.slave: en, sel in; tick_os, tick_mid, tick_bit,
//         rate_idx, sel_err out (all registered)
// ---------------------------------------------------------------------------
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 11_059_200,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int unsigned DIV_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    baud_tick_gen_if.slave  bus
);

    localparam int SUB_W = $clog2(OVERSAMPLE);

    if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_os
        $error("baud_tick_gen: OVERSAMPLE must be even and >= 4");
    end

    // Divisor tables, 8 entries so any 3-bit index is in range; the
    // unused codes alias rate 0.
    logic [DIV_W-1:0] div_tab [8];
`ifdef BAUD_FRAC_EN
    logic [ACC_W-1:0] rem_tab [8];
    logic [ACC_W-1:0] mod_tab [8];
`endif

    for (genvar gi = 0; gi < 8; gi++) begin : g_rate
        localparam int          IDX_G  = (gi < NUM_RATES) ? gi : 0;
        localparam int unsigned BAUD_G = BAUD_TABLE[IDX_G];
        localparam int unsigned D_G    = baud_div(CLK_HZ, BAUD_G, OVERSAMPLE);

        if ((D_G < 2) || (64'(D_G) >= (64'(1) << DIV_W))) begin : g_bad_div
            $error("baud_tick_gen: divisor out of range for rate index %0d", IDX_G);
        end

        assign div_tab[gi] = DIV_W'(D_G);
`ifdef BAUD_FRAC_EN
        assign rem_tab[gi] = ACC_W'(baud_rem(CLK_HZ, BAUD_G, OVERSAMPLE));
        assign mod_tab[gi] = ACC_W'(BAUD_G * OVERSAMPLE);
`endif
    end

    logic             sel_bad;
    rate_idx_t        req_idx;
    logic             apply;
    rate_idx_t        rate_eff;
    logic [DIV_W-1:0] div_sel;
    logic             wrap;
    logic             tick_os;

    rate_idx_t        rate_idx_q, rate_idx_d;
    logic             sel_err_q, sel_err_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [SUB_W-1:0] sub_inc;
    logic             tick_mid_q, tick_mid_d;
    logic             tick_bit_q, tick_bit_d;

    assign sel_bad = (bus.sel >= 3'(NUM_RATES));
    assign req_idx = sel_bad ? DEFAULT_RATE : bus.sel;

    // tick_bit_q is high in the first cycle of the period that follows a bit
    // boundary, so a pending change steers that whole period to the new rate.
    assign apply    = tick_bit_q && (req_idx != rate_idx_q);
    assign rate_eff = apply ? req_idx : rate_idx_q;
    assign div_sel  = div_tab[rate_eff];

`ifdef BAUD_FRAC_EN
    logic [ACC_W-1:0] rem_sel;
    logic [ACC_W-1:0] mod_sel;
    assign rem_sel = rem_tab[rate_eff];
    assign mod_sel = mod_tab[rate_eff];
`endif

    baud_frac_div #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .en_i      (bus.en),
        .load_i    (apply),
        .div_i     (div_sel),
`ifdef BAUD_FRAC_EN
        .rem_i     (rem_sel),
        .mod_i     (mod_sel),
`endif
        .wrap_o    (wrap),
        .tick_os_o (tick_os)
    );

    assign sub_inc = (sub_q == SUB_W'(OVERSAMPLE - 1)) ? '0 : sub_q + 1'b1;

    always_comb begin
        rate_idx_d = rate_idx_q;
        sel_err_d  = sel_bad;
        sub_d      = sub_q;
        tick_mid_d = 1'b0;
        tick_bit_d = 1'b0;
        if (!bus.en) begin
            sub_d      = '0;
            rate_idx_d = req_idx;
        end else begin
            if (apply) begin
                rate_idx_d = req_idx;
            end
            // Mid/bit flags are computed from the sub-index the new tick_os
            // pulse will carry, so they line up with it in the same cycle.
            if (wrap) begin
                sub_d      = sub_inc;
                tick_bit_d = (sub_inc == '0);
                tick_mid_d = (sub_inc == SUB_W'(OVERSAMPLE / 2));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate_idx_q <= DEFAULT_RATE;
            sel_err_q  <= 1'b0;
            sub_q      <= '0;
            tick_mid_q <= 1'b0;
            tick_bit_q <= 1'b0;
        end else begin
            rate_idx_q <= rate_idx_d;
            sel_err_q  <= sel_err_d;
            sub_q      <= sub_d;
            tick_mid_q <= tick_mid_d;
            tick_bit_q <= tick_bit_d;
        end
    end

    assign bus.tick_os  = tick_os;
    assign bus.tick_mid = tick_mid_q;
    assign bus.tick_bit = tick_bit_q;
    assign bus.rate_idx = rate_idx_q;
    assign bus.sel_err  = sel_err_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_baud_tick_gen
// Directed bench for baud_tick_gen: an 11.0592 MHz instance driven from a
// table of {edge, sel, expected outputs} records plus hand-written reset and
// enable sequences, and a 50 MHz instance for the fractional period check.
// ---------------------------------------------------------------------------
module tb_baud_tick_gen;

`ifdef BAUD_FRAC_EN
    localparam int EXP_CYC  = 27126;
    localparam int EXP_LONG = 126;
`else
    localparam int EXP_CYC  = 27000;
    localparam int EXP_LONG = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    baud_tick_gen_if bus0 ();
    baud_tick_gen_if bus1 ();

    baud_tick_gen #(.CLK_HZ(11_059_200), .OVERSAMPLE(16), .DIV_W(16)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    baud_tick_gen #(.CLK_HZ(50_000_000), .OVERSAMPLE(16), .DIV_W(16)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    typedef struct {
        int edge_n;   // edge after which outputs are sampled
        int sel;      // sel driven after the comparison
        int os;
        int mid;
        int bt;
        int rate;
        int err;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;
    int   e     = 0;
    int   b2b   = 0;
    logic prev_os = 1'b0;

    task automatic add(input int en_, input int s, input int os, input int mid,
                       input int bt, input int rate, input int err);
        vec_t v;
        v.edge_n = en_; v.sel = s; v.os = os; v.mid = mid;
        v.bt = bt; v.rate = rate; v.err = err;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s (edge %0d): got %0d expected %0d", name, e, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        @(negedge clk);
        if (bus0.tick_os && prev_os) b2b++;
        prev_os = bus0.tick_os;
    endtask

    task automatic check_all(input string tag, input int os, input int mid,
                             input int bt, input int rate, input int err);
        check({tag, ".tick_os"},  int'(bus0.tick_os),  os);
        check({tag, ".tick_mid"}, int'(bus0.tick_mid), mid);
        check({tag, ".tick_bit"}, int'(bus0.tick_bit), bt);
        check({tag, ".rate_idx"}, int'(bus0.rate_idx), rate);
        check({tag, ".sel_err"},  int'(bus0.sel_err),  err);
    endtask

    initial begin
        int n, ticks, last, longs, odd_gaps, e1000, cnt;

        // edge, sel-after, os, mid, bit, rate, sel_err
        add(   1, 0, 0, 0, 0, 0, 0);
        add(  71, 0, 0, 0, 0, 0, 0);
        add(  72, 0, 1, 0, 0, 0, 0);
        add(  73, 0, 0, 0, 0, 0, 0);
        add( 144, 0, 1, 0, 0, 0, 0);
        add( 576, 0, 1, 1, 0, 0, 0);
        add(1151, 0, 0, 0, 0, 0, 0);
        add(1152, 0, 1, 0, 1, 0, 0);
        add(1153, 0, 0, 0, 0, 0, 0);
        add(1728, 0, 1, 1, 0, 0, 0);
        add(2304, 0, 1, 0, 1, 0, 0);
        // 0 -> 2 -> 0 glitch inside one bit: discarded
        add(2404, 2, 0, 0, 0, 0, 0);
        add(2405, 2, 0, 0, 0, 0, 0);
        add(2500, 0, 0, 0, 0, 0, 0);
        add(3456, 0, 1, 0, 1, 0, 0);
        add(3457, 0, 0, 0, 0, 0, 0);
        add(3474, 0, 0, 0, 0, 0, 0);
        add(3528, 0, 1, 0, 0, 0, 0);
        // real 0 -> 2 change 300 edges into a bit
        add(3756, 2, 0, 0, 0, 0, 0);
        add(4607, 2, 0, 0, 0, 0, 0);
        add(4608, 2, 1, 0, 1, 0, 0);
        add(4609, 2, 0, 0, 0, 2, 0);
        add(4625, 2, 0, 0, 0, 2, 0);
        add(4626, 2, 1, 0, 0, 2, 0);
        add(4644, 2, 1, 0, 0, 2, 0);
        add(4752, 2, 1, 1, 0, 2, 0);
        add(4896, 2, 1, 0, 1, 2, 0);
        // invalid select: sel_err next cycle, falls back to rate 0 at boundary
        add(4900, 6, 0, 0, 0, 2, 0);
        add(4901, 6, 0, 0, 0, 2, 1);
        add(5183, 6, 0, 0, 0, 2, 1);
        add(5184, 6, 1, 0, 1, 2, 1);
        add(5185, 6, 0, 0, 0, 0, 1);
        add(5202, 6, 0, 0, 0, 0, 1);
        add(5256, 6, 1, 0, 0, 0, 1);
        add(5300, 1, 0, 0, 0, 0, 1);
        add(5301, 1, 0, 0, 0, 0, 0);
        add(6336, 1, 1, 0, 1, 0, 0);
        add(6337, 1, 0, 0, 0, 1, 0);
        add(6372, 1, 1, 0, 0, 1, 0);
        add(6408, 1, 1, 0, 0, 1, 0);

        rst = 1'b1;
        bus0.en = 1'b1; bus0.sel = 3'd0;
        bus1.en = 1'b0; bus1.sel = 3'd4;
        repeat (3) @(negedge clk);
        check_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        e = 0;

        foreach (vq[i]) begin
            while (e < vq[i].edge_n) step();
            check_all($sformatf("vec%0d", i), vq[i].os, vq[i].mid, vq[i].bt,
                      vq[i].rate, vq[i].err);
            bus0.sel = 3'(vq[i].sel);
        end

        // Asynchronous reset while a tick is high, rate 1, sel_err set.
        while (e < 6430) step();
        bus0.sel = 3'd6;
        while (e < 6444) step();
        check("pre_rst.tick_os", int'(bus0.tick_os), 1);
        check("pre_rst.sel_err", int'(bus0.sel_err), 1);
        check("pre_rst.rate_idx", int'(bus0.rate_idx), 1);
        #2 rst = 1'b1;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0);
        bus0.sel = 3'd1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        e = 0;
        step();
        check("post_rst.rate_idx", int'(bus0.rate_idx), 0);
        check("post_rst.sel_err", int'(bus0.sel_err), 0);
        while (e < 71) step();
        check("post_rst.tick_os71", int'(bus0.tick_os), 0);
        step();
        check("post_rst.tick_os72", int'(bus0.tick_os), 1);

        // en low for 10 cycles with a new select.
        bus0.en = 1'b0;
        bus0.sel = 3'd3;
        cnt = 0;
        repeat (10) begin
            step();
            cnt += int'(bus0.tick_os) + int'(bus0.tick_mid) + int'(bus0.tick_bit);
        end
        check("en_low.ticks", cnt, 0);
        check("en_low.rate_idx", int'(bus0.rate_idx), 3);
        bus0.en = 1'b1;
        e = 0;
        while (e < 11) step();
        check("en_rise.tick_os11", int'(bus0.tick_os), 0);
        step();
        check("en_rise.tick_os12", int'(bus0.tick_os), 1);
        while (e < 96) step();
        check("en_rise.tick_mid96", int'(bus0.tick_mid), 1);
        while (e < 192) step();
        check("en_rise.tick_bit192", int'(bus0.tick_bit), 1);
        check("no_back_to_back", b2b, 0);

        // 50 MHz, 115200: 1000 consecutive oversample periods.
        check("frac.rate_idx", int'(bus1.rate_idx), 4);
        bus1.en = 1'b1;
        n = 0; ticks = 0; last = 0; longs = 0; odd_gaps = 0; e1000 = -1;
        while ((ticks < 1000) && (n < 40000)) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus1.tick_os) begin
                ticks++;
                if (n - last == 28) longs++;
                else if (n - last != 27) odd_gaps++;
                last = n;
                if (ticks == 1000) e1000 = n;
            end
        end
        check("frac.cycles_1000", e1000, EXP_CYC);
        check("frac.long_periods", longs, EXP_LONG);
        check("frac.odd_gaps", odd_gaps, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
